instr_fetch: RTL and testbench

- Instruction-fetch stage of the multicycle CPU; sits directly upstream of the decode stage.
- When the global controller is in `STATE_IF`, it owns the PC and issues one request per IF visit to instruction memory over a req/ack handshake.
- It latches the returned word into `instruction`, which decode samples during `STATE_ID`.
- It advances the PC by 4, or loads a redirect target supplied by the execute/branch logic.

---
 rtl/instr_fetch.sv | 116 +++++++++++
 tb/tb_instr_fetch.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: one req/ack fetch per STATE_IF visit, latches the
// returned word for decode and advances or redirects the PC.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic        pc_write,
    input  logic [31:0] pc_next,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_done,
    output logic        misaligned
);

    // Global controller encodings, mirrored from the shared state header.
    localparam logic [2:0] STATE_IF = 3'd0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } fetch_state_t;

    fetch_state_t fsm_q, fsm_d;

    logic [31:0] pc_d, addr_d, instr_d, redir_q, redir_d;
    logic        req_d, done_d, mis_d, redir_pend_q, redir_pend_d;

    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q        <= IDLE;
            pc           <= RESET_PC;
            imem_addr    <= RESET_PC;
            imem_req     <= 1'b0;
            instruction  <= '0;
            fetch_done   <= 1'b0;
            misaligned   <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_q      <= '0;
        end else begin
            fsm_q        <= fsm_d;
            pc           <= pc_d;
            imem_addr    <= addr_d;
            imem_req     <= req_d;
            instruction  <= instr_d;
            fetch_done   <= done_d;
            misaligned   <= mis_d;
            redir_pend_q <= redir_pend_d;
            redir_q      <= redir_d;
        end
    end

    always_comb begin
        fsm_d        = fsm_q;
        pc_d         = pc;
        addr_d       = imem_addr;
        req_d        = imem_req;
        instr_d      = instruction;
        done_d       = 1'b0;
        mis_d        = misaligned;
        redir_pend_d = redir_pend_q;
        redir_d      = redir_q;

        case (fsm_q)
            IDLE: begin
                if (pc_write) begin
                    pc_d = pc_next;
                    if (pc_next[1:0] == 2'b00) mis_d = 1'b0;
                end
                // Fetch start uses the PC as it stands this cycle.
                if (state == STATE_IF) begin
                    if (pc[1:0] != 2'b00) begin
                        mis_d = 1'b1;
                    end else if (!misaligned) begin
                        req_d  = 1'b1;
                        addr_d = pc;
                        fsm_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    instr_d      = imem_rdata;
                    req_d        = 1'b0;
                    done_d       = 1'b1;
                    redir_pend_d = 1'b0;
                    if (pc_write)          pc_d = pc_next;
                    else if (redir_pend_q) pc_d = redir_q;
                    else                   pc_d = pc_plus4;
                    fsm_d = DONE;
                end else if (pc_write) begin
                    redir_pend_d = 1'b1;
                    redir_d      = pc_next;
                end
            end
            DONE: begin
                if (pc_write) begin
                    pc_d = pc_next;
                    if (pc_next[1:0] == 2'b00) mis_d = 1'b0;
                end
                if (state != STATE_IF) fsm_d = IDLE;
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios followed by random
// IF visits checked against a transaction-level PC/instruction model.
module tb_instr_fetch;

    localparam logic [2:0] S_IF = 3'd0;
    localparam logic [2:0] S_ID = 3'd1;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  state = S_ID;
    logic        pc_write = 1'b0;
    logic [31:0] pc_next = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_done;
    logic        misaligned;

    instr_fetch #(.RESET_PC(RST_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .state      (state),
        .pc_write   (pc_write),
        .pc_next    (pc_next),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .instruction(instruction),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .fetch_done (fetch_done),
        .misaligned (misaligned)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc    = RST_PC;
    logic [31:0] m_instr = '0;
    logic        m_mis   = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_arch(input string tag);
        check({tag, ".pc"}, pc, m_pc);
        check({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".instr"}, instruction, m_instr);
        check({tag, ".mis"}, {31'd0, misaligned}, {31'd0, m_mis});
    endtask

    task automatic redirect_idle(input logic [31:0] tgt);
        state    = S_ID;
        pc_write = 1'b1;
        pc_next  = tgt;
        tick();
        pc_write = 1'b0;
        m_pc = tgt;
        if (tgt[1:0] == 2'b00) m_mis = 1'b0;
        check_arch("redir");
    endtask

    // One IF visit. redir_at < 0: no redirect during the fetch; otherwise a
    // pc_write pulse is given redir_at cycles after the request starts.
    task automatic do_visit(input int waits, input int redir_at, input logic [31:0] tgt,
                            input bit late_redir, input logic [31:0] tgt2,
                            input int linger, input logic [31:0] word);
        logic [31:0] fetch_pc;
        logic [31:0] exp_pc;
        state = S_IF;
        tick();
        if (m_pc[1:0] != 2'b00 || m_mis) begin
            m_mis = 1'b1;
            check("mis.req", {31'd0, imem_req}, 32'd0);
            check_arch("mis");
            state = S_ID;
            tick();
            check("mis.req2", {31'd0, imem_req}, 32'd0);
            return;
        end
        fetch_pc = m_pc;
        exp_pc   = m_pc + 32'd4;
        check("start.req", {31'd0, imem_req}, 32'd1);
        check("start.addr", imem_addr, fetch_pc);
        for (int w = 0; w < waits; w++) begin
            imem_ack = 1'b0;
            pc_write = (redir_at == w);
            pc_next  = tgt;
            if (redir_at == w) exp_pc = tgt;
            tick();
            pc_write = 1'b0;
            check("wait.req", {31'd0, imem_req}, 32'd1);
            check("wait.addr", imem_addr, fetch_pc);
            check("wait.done", {31'd0, fetch_done}, 32'd0);
            check("wait.pc", pc, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        if (redir_at == waits) begin
            pc_write = 1'b1; pc_next = tgt; exp_pc = tgt;
        end else if (late_redir) begin
            pc_write = 1'b1; pc_next = tgt2; exp_pc = tgt2;
        end
        tick();
        imem_ack = 1'b0;
        pc_write = 1'b0;
        m_pc    = exp_pc;
        m_instr = word;
        check("ack.done", {31'd0, fetch_done}, 32'd1);
        check("ack.req", {31'd0, imem_req}, 32'd0);
        check_arch("ack");
        for (int l = 0; l < linger; l++) begin
            imem_ack   = $urandom_range(0, 1);
            imem_rdata = $urandom;
            tick();
            check("linger.req", {31'd0, imem_req}, 32'd0);
            check("linger.done", {31'd0, fetch_done}, 32'd0);
            check("linger.instr", instruction, m_instr);
        end
        imem_ack = 1'b0;
        state = S_ID;
        tick();
        check("id.done", {31'd0, fetch_done}, 32'd0);
        check_arch("id");
    endtask

    initial begin
        #2;
        check("rst.req", {31'd0, imem_req}, 32'd0);
        check("rst.addr", imem_addr, RST_PC);
        check("rst.done", {31'd0, fetch_done}, 32'd0);
        check_arch("rst");
        tick();
        rst_n = 1'b1;
        tick();

        // Zero-wait fetch, then 3-wait fetch lingering in IF
        do_visit(0, -1, '0, 1'b0, '0, 0, 32'h2002_0005);
        do_visit(3, -1, '0, 1'b0, '0, 2, 32'h1111_2222);
        // Redirect during WAIT at pc=8
        do_visit(2, 0, 32'h0000_0040, 1'b0, '0, 0, 32'h3333_4444);
        do_visit(0, -1, '0, 1'b0, '0, 0, 32'h5555_6666);
        // Pending redirect overridden by same-cycle pc_write on ack
        do_visit(2, 1, 32'h0000_0100, 1'b1, 32'h0000_0200, 0, 32'h7777_8888);
        // PC wrap
        redirect_idle(32'hFFFF_FFFC);
        do_visit(1, -1, '0, 1'b0, '0, 1, 32'h9999_AAAA);
        check("wrap.pc", pc, 32'h0);
        check("wrap.pc4", pc_plus4, 32'h4);
        // Misaligned PC blocks fetch until an aligned redirect
        redirect_idle(32'h0000_0042);
        do_visit(0, -1, '0, 1'b0, '0, 0, 32'hDEAD_BEEF);
        check("mis.flag", {31'd0, misaligned}, 32'd1);
        redirect_idle(32'h0000_0044);
        do_visit(0, -1, '0, 1'b0, '0, 0, 32'hCAFE_F00D);

        // Reset asserted mid-WAIT
        redirect_idle(32'h0000_0010);
        state = S_IF;
        tick();
        check("rw.req", {31'd0, imem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rw.req0", {31'd0, imem_req}, 32'd0);
        m_pc = RST_PC; m_instr = '0; m_mis = 1'b0;
        check_arch("rw");
        state = S_ID;
        tick();
        rst_n = 1'b1;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        tick();
        imem_ack = 1'b0;
        check("rw.stray_done", {31'd0, fetch_done}, 32'd0);
        check_arch("rw.stray");

        // Random visits
        for (int i = 0; i < 60; i++) begin
            logic [31:0] t1, t2;
            int w, ra;
            if ($urandom_range(0, 3) == 0) begin
                t1 = $urandom;
                if ($urandom_range(0, 3) != 0) t1[1:0] = 2'b00;
                redirect_idle(t1);
            end
            w  = $urandom_range(0, 3);
            ra = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, w)) : -1;
            t1 = $urandom;
            t2 = $urandom;
            if ($urandom_range(0, 4) != 0) t1[1:0] = 2'b00;
            t2[1:0] = 2'b00;
            if (t1 == 32'hFFFF_FFFF) t1 = '0;
            do_visit(w, ra, t1, ($urandom_range(0, 3) == 0), t2,
                     $urandom_range(0, 2), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
